// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// Every bit lasts PRESCALE clocks; all frame settings are captured when the frame is accepted.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  logic [4:0]            cnt_r;
  logic [4:0]            prescale_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic                  tx_out_r;
  logic                  busy_r;
  logic                  bit_done_s;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // End of the current bit period; prescale 0 and 1 both mean one-clock bits
  always_comb begin
    bit_done_s = 1'b0;
    if (prescale_r <= 5'd1) begin
      bit_done_s = 1'b1;
    end else begin
      bit_done_s = (cnt_r == (prescale_r - 5'd1));
    end
  end

  // Frame sequencer with registered line and busy outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= IDLE;
      cnt_r      <= 5'd0;
      prescale_r <= 5'd0;
      idx_r      <= '0;
      shift_r    <= '0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      tx_out_r   <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      if (state_r != IDLE) begin
        cnt_r <= bit_done_s ? 5'd0 : (cnt_r + 5'd1);
      end else begin
        cnt_r <= 5'd0;
      end
      case (state_r)
        IDLE: begin
          tx_out_r <= 1'b1;
          busy_r   <= 1'b0;
          if (DATA_VALID) begin
            prescale_r <= PRESCALE;
            par_en_r   <= PAR_EN;
            par_bit_r  <= calc_parity(P_DATA, PAR_TYP);
            shift_r    <= P_DATA;
            idx_r      <= '0;
            tx_out_r   <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= START;
          end
        end
        START: begin
          if (bit_done_s) begin
            tx_out_r <= shift_r[0];
            shift_r  <= shift_r >> 1;
            idx_r    <= '0;
            state_r  <= DATA;
          end
        end
        DATA: begin
          if (bit_done_s) begin
            if (idx_r == LAST_IDX) begin
              if (par_en_r) begin
                tx_out_r <= par_bit_r;
                state_r  <= PARITY;
              end else begin
                tx_out_r <= 1'b1;
                state_r  <= STOP;
              end
            end else begin
              idx_r    <= idx_r + 1'b1;
              tx_out_r <= shift_r[0];
              shift_r  <= shift_r >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_done_s) begin
            tx_out_r <= 1'b1;
            state_r  <= STOP;
          end
        end
        STOP: begin
          if (bit_done_s) begin
            tx_out_r <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          tx_out_r <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_out_r;
  assign BUSY   = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, random frames against a bit-list model,
// plus mid-frame reset and back-to-back corner cases.
module tb_uart_tx;

  logic       CLK_tb = 1'b0;
  logic       RST;
  logic [4:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       TX_OUT;
  logic       BUSY;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 CLK_tb = ~CLK_tb;
  always @(posedge CLK_tb) cyc <= cyc + 1;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK_tb), .RST(RST), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  typedef struct {
    logic [4:0] ps;
    logic       pe;
    logic       pt;
    logic [7:0] data;
    logic       intf;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: frame is a list of bit values, each held for p clocks.
  task automatic run_frame(input logic [4:0] ps, input logic pe, input logic pt, input logic [7:0] d,
                           input logic intf, input logic exp_par, input int exp_len, input bit use_exp);
    int   p, nb, f, busy_cnt;
    logic par_seen;
    logic bits[11];
    p  = (ps <= 5'd1) ? 1 : int'(ps);
    nb = pe ? 11 : 10;
    f  = p * nb;
    bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) bits[1+j] = d[j];
    if (pe) bits[9] = logic'($countones(d) % 2) ^ pt;
    bits[nb-1] = 1'b1;
    par_seen = 1'b0;
    busy_cnt = 0;
    @(negedge CLK_tb);
    PRESCALE = ps; PAR_EN = pe; PAR_TYP = pt; P_DATA = d; DATA_VALID = 1'b1;
    @(posedge CLK_tb); #1;
    DATA_VALID = 1'b0;
    for (int i = 0; i < f; i++) begin
      if (i > 0) begin
        @(posedge CLK_tb); #1;
      end
      if (intf && i == 3*p) begin
        DATA_VALID = 1'b1; P_DATA = 8'hFF; PAR_TYP = ~pt; PRESCALE = ps ^ 5'h0A; PAR_EN = ~pe;
      end
      if (intf && i == 3*p + 2) DATA_VALID = 1'b0;
      if (i == 9*p) par_seen = TX_OUT;
      chk("tx_bit", TX_OUT, bits[i/p]);
      chk("busy", BUSY, 1'b1);
      busy_cnt += int'(BUSY);
    end
    repeat (2) begin
      @(posedge CLK_tb); #1;
      chk("idle_tx", TX_OUT, 1'b1);
      chk("idle_busy", BUSY, 1'b0);
    end
    if (use_exp) begin
      chk("busy_len", busy_cnt, exp_len);
      if (pe) chk("parity", par_seen, exp_par);
    end
  endtask

  initial begin
    int start1, start2, idle_cnt;
    RST = 1'b1; DATA_VALID = 1'b0; PRESCALE = 5'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0; P_DATA = 8'h00;

    repeat (3) @(posedge CLK_tb);
    #1;
    chk("reset_tx", TX_OUT, 1'b1);
    chk("reset_busy", BUSY, 1'b0);
    @(negedge CLK_tb); RST = 1'b0;
    @(posedge CLK_tb); #1;
    chk("post_reset_tx", TX_OUT, 1'b1);
    chk("post_reset_busy", BUSY, 1'b0);

    //         ps     pe    pt    data   intf  par   len
    vecs[0] = '{5'd16, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 176};
    vecs[1] = '{5'd8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 80};
    vecs[2] = '{5'd16, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 176};
    vecs[3] = '{5'd16, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 176};
    vecs[4] = '{5'd0,  1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 11};
    vecs[5] = '{5'd1,  1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 10};
    vecs[6] = '{5'd5,  1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 55};
    vecs[7] = '{5'd31, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 310};
    vecs[8] = '{5'd3,  1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 33};
    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].ps, vecs[v].pe, vecs[v].pt, vecs[v].data, vecs[v].intf,
                vecs[v].exp_par, vecs[v].exp_len, 1'b1);
    end

    for (int r = 0; r < 15; r++) begin
      run_frame(5'($urandom_range(0, 12)), 1'($urandom), 1'($urandom), 8'($urandom),
                1'($urandom), 1'b0, 0, 1'b0);
    end

    // Reset during data bit 3 of an all-zero frame
    @(negedge CLK_tb);
    PRESCALE = 5'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; P_DATA = 8'h00; DATA_VALID = 1'b1;
    @(posedge CLK_tb); #1;
    DATA_VALID = 1'b0;
    repeat (4*16 + 5) @(posedge CLK_tb);
    #1;
    chk("rst_pre_tx", TX_OUT, 1'b0);
    #2 RST = 1'b1;
    #1;
    chk("rst_async_tx", TX_OUT, 1'b1);
    chk("rst_async_busy", BUSY, 1'b0);
    @(posedge CLK_tb);
    @(negedge CLK_tb); RST = 1'b0;
    repeat (3) begin
      @(posedge CLK_tb); #1;
      chk("post_abort_tx", TX_OUT, 1'b1);
      chk("post_abort_busy", BUSY, 1'b0);
    end
    run_frame(5'd16, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 176, 1'b1);

    // Back-to-back with DATA_VALID held high
    @(negedge CLK_tb);
    PRESCALE = 5'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; P_DATA = 8'h96; DATA_VALID = 1'b1;
    @(posedge CLK_tb); #1;
    start1 = cyc;
    chk("b2b_first_busy", BUSY, 1'b1);
    idle_cnt = 0;
    start2   = -1;
    for (int i = 0; i < 400 && start2 < 0; i++) begin
      @(posedge CLK_tb); #1;
      if (!BUSY) begin
        idle_cnt++;
        chk("b2b_idle_tx", TX_OUT, 1'b1);
      end else if (idle_cnt > 0) begin
        start2 = cyc;
      end
    end
    DATA_VALID = 1'b0;
    chk("b2b_gap", start2 - start1, 177);
    chk("b2b_idle_cnt", idle_cnt, 1);
    chk("b2b_start2_tx", TX_OUT, 1'b0);
    for (int i = 0; i < 400 && BUSY; i++) begin
      @(posedge CLK_tb); #1;
    end
    chk("b2b_end_busy", BUSY, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
